if_stage_controller: RTL and testbench
======================================

// Module: if_stage_controller
// PURPOSE
//  Sequencer for the instruction-fetch stage (PC register, PC+4 adder, next-PC mux).
//  Drives the PC write enable, next-PC mux select, IF/ID write/flush and ID/EX bubble.
//  Handles instruction-memory waits, load-use stalls, taken-branch redirects and halt.
//  Sits between the hazard/branch logic of ID/EX/MEM and the IF datapath.
// PARAMETERS
//  REG_W        5   register-specifier width
//  CNT_W        16  width of the saturating performance counters
//  FLUSH_SLOTS  1   cycles IF/ID flush is held per redirect (1..4)
//  WAIT_TIMEOUT 15  max consecutive MEM_WAIT cycles before ERROR (1..255)
// PORTS
//  clock          in  1      rising-edge clock
//  reset_n        in  1      asynchronous, active-low reset
//  imem_ack       in  1      instruction word valid this cycle
//  id_ex_mem_read in  1      instruction in EX is a load
//  id_ex_rt       in  REG_W  load destination register
//  if_id_rs       in  REG_W  rs of instruction in ID
//  if_id_rt       in  REG_W  rt of instruction in ID
//  branch_taken   in  1      taken branch/jump resolved in MEM; target is on the mux's branch input
//  halt           in  1      decoded halt in the fetched word
//  imem_req       out 1      fetch request to instruction memory
//  pc_write       out 1      PC register write enable
//  pc_sel         out 1      next-PC mux select: 1 = branch target, 0 = PC+4
//  if_id_write    out 1      IF/ID register write enable
//  if_id_flush    out 1      IF/ID loads a NOP
//  id_ex_bubble   out 1      ID/EX control signals forced to zero
//  halted         out 1      state == HALTED
//  error          out 1      state == ERROR
//  stall_cycles   out CNT_W  cycles with imem_req=1 and pc_write=0
//  flush_count    out CNT_W  redirects taken
// BEHAVIOUR
//  Outputs are combinational from state and inputs (Mealy). Counters are registered.
//  While reset_n=0: state=IDLE, all outputs 0, counters 0, wait_cnt=0, slot_cnt=0.
//  load_use = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
//  Priority in FETCH/MEM_WAIT/REDIRECT: branch_taken > load_use > imem_ack wait > halt > advance.
//  IDLE: all outputs 0; next state FETCH unconditionally.
//  FETCH: imem_req=1.
//   branch_taken: pc_sel=1, pc_write=1, if_id_flush=1, id_ex_bubble=1, imem_req=0;
//    flush_count++; go REDIRECT with slot_cnt=FLUSH_SLOTS-1 if FLUSH_SLOTS>1, else FETCH.
//   load_use: pc_write=0, if_id_write=0, id_ex_bubble=1; stay FETCH.
//   !imem_ack: pc_write=0, if_id_write=0; wait_cnt=1; go MEM_WAIT.
//   halt & imem_ack: pc_write=0, if_id_write=1; go HALTED.
//   else: pc_write=1, pc_sel=0, if_id_write=1.
//  MEM_WAIT: imem_req=1, pc_write=0, if_id_write=0; wait_cnt++ each cycle.
//   imem_ack: same as FETCH advance; go FETCH; wait_cnt=0.
//   wait_cnt==WAIT_TIMEOUT and !imem_ack: go ERROR.
//   branch_taken: same as FETCH branch; abandons the outstanding fetch; wait_cnt=0.
//  REDIRECT: imem_req=1, if_id_flush=1, pc_write=imem_ack, pc_sel=0; slot_cnt--.
//   Go FETCH when slot_cnt reaches 0. A new branch_taken restarts the redirect.
//  HALTED/ERROR: absorbing until reset_n=0; all enables 0, halted/error=1.
//  Counters saturate at all-ones and never wrap.
//  Reset asserted mid-stall or mid-wait returns to IDLE immediately (asynchronous).
//  Pending stalls and redirects are discarded on reset.
// STRUCTURE
//  Shared package if_ctrl_pkg:
//   state encoding (IDLE, FETCH, MEM_WAIT, REDIRECT, HALTED, ERROR)
//   REG_ZERO constant
//   NOP encoding used by the IF/ID flush
//  Sub-module load_use_detect: combinational compare producing load_use.
//  FSM, wait/slot counters and performance counters stay in this module.
// TESTING
//  1 reset_n=0 then 1, imem_ack=1 always -> IDLE for 1 cycle; pc_write=1 and pc_sel=0 from cycle 2; counters 0.
//  2 id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1.
//    Repeat with id_ex_rt=0 -> no stall.
//  3 imem_ack=0 for 3 cycles -> MEM_WAIT, pc_write=0, stall_cycles=3; ack -> advance.
//    Hold ack=0 for 16 cycles -> error=1.
//  4 branch_taken during MEM_WAIT, FLUSH_SLOTS=2 -> pc_sel=1, pc_write=1, if_id_flush=1 for 2 cycles; flush_count=1.
//  5 branch_taken and load_use in the same cycle -> branch wins: pc_write=1, pc_sel=1, id_ex_bubble=1.
//  6 halt with imem_ack -> halted=1, pc_write=0 thereafter; reset_n pulse mid-HALTED -> IDLE, halted=0.
//    CNT_W=4 with 20 stalls -> stall_cycles=15.

Source files
------------

// File: rtl/if_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// if_ctrl_pkg
// Shared definitions for the instruction-fetch stage controller:
//   ifState_e - sequencer state encoding
//   REG_ZERO  - the hard-wired zero register specifier (never a real hazard)
//   NOP_INSN  - instruction word the IF/ID register loads when flushed
// ----------------------------------------------------------------------------
package if_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALTED   = 3'd4,
        ST_ERROR    = 3'd5
    } ifState_e;

    localparam int REG_ZERO = 0;

    // sll $0,$0,0 - the canonical all-zero NOP
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/if_stage_controller_load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect
// Flags a load-use hazard: the instruction in EX is a load whose destination
// register (other than the zero register) is a source of the instruction in ID.
// Ports:
//   i_memRead - instruction in EX is a load
//   i_exRt    - load destination register
//   i_idRs    - rs of instruction in ID
//   i_idRt    - rt of instruction in ID
//   o_loadUse - hazard present this cycle
// ----------------------------------------------------------------------------
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_memRead,
    input  logic [REG_W-1:0] i_exRt,
    input  logic [REG_W-1:0] i_idRs,
    input  logic [REG_W-1:0] i_idRt,
    output logic             o_loadUse
);
    import if_ctrl_pkg::*;

    assign o_loadUse = i_memRead
                    && (i_exRt != REG_W'(REG_ZERO))
                    && ((i_exRt == i_idRs) || (i_exRt == i_idRt));

endmodule

// File: rtl/if_stage_controller.sv
// ----------------------------------------------------------------------------
// if_stage_controller
// Sequencer for the instruction-fetch stage. Drives the PC write enable, the
// next-PC mux select, IF/ID write/flush and the ID/EX bubble, reacting to
// instruction-memory waits, load-use stalls, taken-branch redirects and halt.
// Outputs are Mealy (state + inputs); performance counters are registered.
// Ports:
//   clock, reset_n  - rising-edge clock, asynchronous active-low reset
//   imem_ack        - instruction word valid this cycle
//   id_ex_mem_read  - instruction in EX is a load
//   id_ex_rt        - load destination register
//   if_id_rs/rt     - source registers of instruction in ID
//   branch_taken    - taken branch resolved in MEM
//   halt            - decoded halt in the fetched word
//   imem_req        - fetch request
//   pc_write/pc_sel - PC enable / next-PC select (1 = branch target)
//   if_id_write/if_id_flush - IF/ID enable / load NOP
//   id_ex_bubble    - zero the ID/EX control signals
//   halted/error    - absorbing terminal states
//   stall_cycles    - saturating count of cycles with imem_req=1, pc_write=0
//   flush_count     - saturating count of redirects taken
// ----------------------------------------------------------------------------
module if_stage_controller #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int FLUSH_SLOTS  = 1,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             imem_ack,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             branch_taken,
    input  logic             halt,
    output logic             imem_req,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    import if_ctrl_pkg::*;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);
    localparam logic [1:0] SLOT_INIT  = 2'(FLUSH_SLOTS - 1);

    ifState_e         r_state;
    ifState_e         w_nextState;
    logic [7:0]       r_waitCnt;
    logic [7:0]       w_nextWaitCnt;
    logic [1:0]       r_slotCnt;
    logic [1:0]       w_nextSlotCnt;
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCount;
    logic             w_loadUse;

    load_use_detect #(.REG_W(REG_W)) u_loadUse (
        .i_memRead (id_ex_mem_read),
        .i_exRt    (id_ex_rt),
        .i_idRs    (if_id_rs),
        .i_idRt    (if_id_rt),
        .o_loadUse (w_loadUse)
    );

    // State, wait and slot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= 8'd0;
            r_slotCnt <= 2'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            r_slotCnt <= w_nextSlotCnt;
        end
    end

    // Next-state logic. A taken branch always wins; with a single flush slot
    // the branch cycle itself is the whole redirect and we return to FETCH.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_nextSlotCnt = r_slotCnt;
        case (r_state)
            ST_IDLE: w_nextState = ST_FETCH;
            ST_FETCH, ST_MEM_WAIT, ST_REDIRECT: begin
                if (branch_taken) begin
                    w_nextWaitCnt = 8'd0;
                    if (FLUSH_SLOTS > 1) begin
                        w_nextState   = ST_REDIRECT;
                        w_nextSlotCnt = SLOT_INIT;
                    end else begin
                        w_nextState   = ST_FETCH;
                        w_nextSlotCnt = 2'd0;
                    end
                end else if (r_state == ST_REDIRECT) begin
                    if (r_slotCnt <= 2'd1) begin
                        w_nextSlotCnt = 2'd0;
                        w_nextState   = ST_FETCH;
                    end else begin
                        w_nextSlotCnt = r_slotCnt - 2'd1;
                    end
                end else if (r_state == ST_FETCH) begin
                    if (w_loadUse) begin
                        w_nextState = ST_FETCH;
                    end else if (!imem_ack) begin
                        w_nextWaitCnt = 8'd1;
                        w_nextState   = ST_MEM_WAIT;
                    end else if (halt) begin
                        w_nextState = ST_HALTED;
                    end
                end else begin
                    // MEM_WAIT: an ack under a load-use stall is dropped; the
                    // PC was not written so FETCH simply re-requests it.
                    if (imem_ack) begin
                        w_nextWaitCnt = 8'd0;
                        w_nextState   = (halt && !w_loadUse) ? ST_HALTED : ST_FETCH;
                    end else if (r_waitCnt == WAIT_LIMIT) begin
                        w_nextState = ST_ERROR;
                    end else begin
                        w_nextWaitCnt = r_waitCnt + 8'd1;
                    end
                end
            end
            default: w_nextState = r_state;
        endcase
    end

    // Mealy outputs. FETCH and MEM_WAIT share one decision ladder because in
    // MEM_WAIT imem_ack is simply still low until the word arrives.
    always_comb begin
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        error        = 1'b0;
        case (r_state)
            ST_FETCH, ST_MEM_WAIT: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    imem_req     = 1'b0;
                    pc_sel       = 1'b1;
                    pc_write     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (w_loadUse) begin
                    id_ex_bubble = 1'b1;
                end else if (imem_ack) begin
                    if_id_write = 1'b1;
                    pc_write    = !halt;
                end
            end
            ST_REDIRECT: begin
                imem_req    = 1'b1;
                if_id_flush = 1'b1;
                if (branch_taken) begin
                    imem_req     = 1'b0;
                    pc_sel       = 1'b1;
                    pc_write     = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (w_loadUse) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_write = imem_ack;
                end
            end
            ST_HALTED: halted = 1'b1;
            ST_ERROR:  error  = 1'b1;
            default: ;
        endcase
    end

    // Saturating performance counters; pc_sel is high exactly on redirects
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (imem_req && !pc_write && (r_stallCycles != '1))
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            if (pc_sel && (r_flushCount != '1))
                r_flushCount <= r_flushCount + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;

endmodule

// File: tb/tb_if_stage_controller.sv
// ----------------------------------------------------------------------------
// tb_if_stage_controller
// Directed bench for if_stage_controller. Two instances share one stimulus:
// dut (16-bit counters) and dutSat (4-bit counters, to observe saturation).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit
// later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_if_stage_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       imem_ack;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       branch_taken;
    logic       halt;

    logic        imem_req, pc_write, pc_sel, if_id_write, if_id_flush;
    logic        id_ex_bubble, halted, error;
    logic [15:0] stall_cycles, flush_count;

    logic        sImemReq, sPcWrite, sPcSel, sIfIdWrite, sIfIdFlush;
    logic        sIdExBubble, sHalted, sError;
    logic [3:0]  sStallCycles, sFlushCount;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    if_stage_controller #(.REG_W(5), .CNT_W(16), .FLUSH_SLOTS(2), .WAIT_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .imem_ack(imem_ack),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .halt(halt),
        .imem_req(imem_req), .pc_write(pc_write), .pc_sel(pc_sel),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .halted(halted), .error(error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    if_stage_controller #(.REG_W(5), .CNT_W(4), .FLUSH_SLOTS(2), .WAIT_TIMEOUT(15)) dutSat (
        .clock(clock), .reset_n(reset_n), .imem_ack(imem_ack),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .branch_taken(branch_taken), .halt(halt),
        .imem_req(sImemReq), .pc_write(sPcWrite), .pc_sel(sPcSel),
        .if_id_write(sIfIdWrite), .if_id_flush(sIfIdFlush),
        .id_ex_bubble(sIdExBubble), .halted(sHalted), .error(sError),
        .stall_cycles(sStallCycles), .flush_count(sFlushCount)
    );

    // Advance to just after the next rising edge
    task tick;
        @(posedge clock);
        #1;
    endtask

    // Drive every DUT input, then let the combinational outputs settle
    task applyStimulus(input logic ack, input logic memRead, input logic [4:0] exRt,
                       input logic [4:0] idRs, input logic [4:0] idRt,
                       input logic branch, input logic haltIn);
        imem_ack       = ack;
        id_ex_mem_read = memRead;
        id_ex_rt       = exRt;
        if_id_rs       = idRs;
        if_id_rt       = idRt;
        branch_taken   = branch;
        halt           = haltIn;
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Reset held across two edges: everything quiet, counters cleared
        repeat (2) tick();
        checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_pc_write", {31'd0, pc_write}, 32'd0);
        checkOutput("rst_stall", {16'd0, stall_cycles}, 32'd0);
        checkOutput("rst_flush", {16'd0, flush_count}, 32'd0);

        // Release: one IDLE cycle, then FETCH advancing with ack=1
        reset_n = 1'b1;
        #1;
        checkOutput("idle_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        checkOutput("fetch_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("fetch_pc_sel", {31'd0, pc_sel}, 32'd0);
        checkOutput("fetch_if_id_write", {31'd0, if_id_write}, 32'd1);

        // Load-use on rs=5 for one cycle
        applyStimulus(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_pc_write", {31'd0, pc_write}, 32'd0);
        checkOutput("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        checkOutput("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_stall_cnt", {16'd0, stall_cycles}, 32'd1);

        // Load into register zero is never a hazard
        applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu_zero_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("lu_zero_bubble", {31'd0, id_ex_bubble}, 32'd0);
        tick();
        checkOutput("lu_zero_stall_cnt", {16'd0, stall_cycles}, 32'd1);

        // Three cycles without ack, then ack advances
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            checkOutput("wait_pc_write", {31'd0, pc_write}, 32'd0);
            tick();
        end
        checkOutput("wait_stall_cnt", {16'd0, stall_cycles}, 32'd4);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("wait_ack_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("wait_ack_if_id_write", {31'd0, if_id_write}, 32'd1);
        tick();
        checkOutput("wait_done_stall_cnt", {16'd0, stall_cycles}, 32'd4);

        // Sixteen cycles without ack reach ERROR; fifteen do not
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (15) tick();
        checkOutput("timeout_not_yet", {31'd0, error}, 32'd0);
        tick();
        checkOutput("timeout_error", {31'd0, error}, 32'd1);
        checkOutput("timeout_stall_cnt", {16'd0, stall_cycles}, 32'd20);
        checkOutput("timeout_sat_cnt", {28'd0, sStallCycles}, 32'd15);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("error_pc_write", {31'd0, pc_write}, 32'd0);
        checkOutput("error_imem_req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("error_sticky", {31'd0, error}, 32'd1);

        // Asynchronous reset out of ERROR
        reset_n = 1'b0;
        #1;
        checkOutput("rst_err_error", {31'd0, error}, 32'd0);
        checkOutput("rst_err_stall", {16'd0, stall_cycles}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Branch in MEM_WAIT with two flush slots
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("br_pc_sel", {31'd0, pc_sel}, 32'd1);
        checkOutput("br_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("br_flush", {31'd0, if_id_flush}, 32'd1);
        checkOutput("br_imem_req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("br_flush_cnt", {16'd0, flush_count}, 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("redir_flush", {31'd0, if_id_flush}, 32'd1);
        checkOutput("redir_pc_sel", {31'd0, pc_sel}, 32'd0);
        checkOutput("redir_pc_write", {31'd0, pc_write}, 32'd1);
        tick();
        checkOutput("redir_done_flush", {31'd0, if_id_flush}, 32'd0);
        checkOutput("redir_done_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("redir_done_flush_cnt", {16'd0, flush_count}, 32'd1);

        // Branch and load-use together: branch wins
        applyStimulus(1'b1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0);
        checkOutput("brlu_pc_write", {31'd0, pc_write}, 32'd1);
        checkOutput("brlu_pc_sel", {31'd0, pc_sel}, 32'd1);
        checkOutput("brlu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick();
        checkOutput("brlu_flush_cnt", {16'd0, flush_count}, 32'd2);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // Halt with ack: fetch word latched, PC frozen, then HALTED
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("halt_pc_write", {31'd0, pc_write}, 32'd0);
        checkOutput("halt_if_id_write", {31'd0, if_id_write}, 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("halted_flag", {31'd0, halted}, 32'd1);
        checkOutput("halted_pc_write", {31'd0, pc_write}, 32'd0);
        tick();
        checkOutput("halted_sticky", {31'd0, halted}, 32'd1);

        // Reset pulse mid-HALTED returns to IDLE
        reset_n = 1'b0;
        #1;
        checkOutput("rst_halt_halted", {31'd0, halted}, 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_halt_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        checkOutput("rst_halt_fetch", {31'd0, pc_write}, 32'd1);

        // Twenty load-use stalls: 16-bit counter reads 20, 4-bit saturates at 15
        applyStimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
        repeat (20) tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("sat_stall_wide", {16'd0, stall_cycles}, 32'd20);
        checkOutput("sat_stall_narrow", {28'd0, sStallCycles}, 32'd15);
        checkOutput("sat_flush_narrow", {28'd0, sFlushCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
